// File: rtl/dsp_mac_sequencer_if.sv
// Command, operand, result and DSP-slice signal bundle for dsp_mac_sequencer.
// The slave modport is the sequencer side; master is the side that issues commands.
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 16
) ();
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [LEN_W-1:0]        cmd_len;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [17:0]      in_a;
    logic signed [17:0]      in_b;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [47:0]      res_data;
    logic                    busy;
    logic signed [17:0]      dsp_a;
    logic signed [17:0]      dsp_b;
    logic [7:0]              dsp_opmode;
    logic                    dsp_cea;
    logic                    dsp_ceb;
    logic                    dsp_cem;
    logic                    dsp_ceopmode;
    logic                    dsp_cep;
    logic                    dsp_rstp;
    logic signed [47:0]      dsp_p;

    modport slave (
        input  cmd_valid, cmd_len, in_valid, in_a, in_b, res_ready, dsp_p,
        output cmd_ready, in_ready, res_valid, res_data, busy,
               dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb, dsp_cem,
               dsp_ceopmode, dsp_cep, dsp_rstp
    );

    modport master (
        output cmd_valid, cmd_len, in_valid, in_a, in_b, res_ready, dsp_p,
        input  cmd_ready, in_ready, res_valid, res_data, busy,
               dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb, dsp_cem,
               dsp_ceopmode, dsp_cep, dsp_rstp
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1 slice (A1/B1, M, P and OPMODE registered) as a dot-product MAC:
// streams N operand pairs, steers OPMODE/CEP along the slice latency, returns P.
module dsp_mac_sequencer #(
    parameter int LEN_W    = 16,
    parameter int PIPE_LAT = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    dsp_mac_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_RESULT
    } state_t;

    state_t                 r_state;
    logic                   r_cmd_ready;
    logic                   r_in_ready;
    logic                   r_res_valid;
    logic                   r_busy;
    logic signed [47:0]     r_res_data;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_count;

    logic                   r_t_p1;
    logic                   r_f_p1;
    logic                   r_t_p2;
    logic [PIPE_LAT-1:0]    r_last_p;

    logic                   w_acc;
    logic                   w_first;
    logic                   w_last;

    assign w_acc   = bus.in_valid & r_in_ready;
    assign w_first = w_acc & (r_count == '0);
    assign w_last  = w_acc & (r_count == (r_len - LEN_W'(1)));

    // Stage 0 -> 1 -> 2: accept tag, first-sample flag and last-sample marker
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_t_p1   <= 1'b0;
            r_f_p1   <= 1'b0;
            r_t_p2   <= 1'b0;
            r_last_p <= '0;
        end else begin
            r_t_p1   <= w_acc;
            r_f_p1   <= w_first;
            r_t_p2   <= r_t_p1;
            r_last_p <= {r_last_p[PIPE_LAT-2:0], w_last};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
            r_len       <= '0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_cmd_ready && bus.cmd_valid) begin
                        r_len       <= bus.cmd_len;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.cmd_len == '0) begin
                            r_res_data  <= '0;
                            r_res_valid <= 1'b1;
                            r_state     <= S_RESULT;
                        end else begin
                            r_count    <= '0;
                            r_in_ready <= 1'b1;
                            r_state    <= S_STREAM;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (w_acc) begin
                        r_count <= r_count + LEN_W'(1);
                        if (w_last) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Marker reaches the end exactly when P holds the final sum
                    if (r_last_p[PIPE_LAT-1]) begin
                        r_res_data  <= bus.dsp_p;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready    = r_cmd_ready;
    assign bus.in_ready     = r_in_ready;
    assign bus.res_valid    = r_res_valid;
    assign bus.res_data     = r_res_data;
    assign bus.busy         = r_busy;

    assign bus.dsp_a        = bus.in_a;
    assign bus.dsp_b        = bus.in_b;
    // Z=0 on the first product clears the previous command's accumulation
    assign bus.dsp_opmode   = r_f_p1 ? 8'h01 : 8'h09;
    assign bus.dsp_cea      = 1'b1;
    assign bus.dsp_ceb      = 1'b1;
    assign bus.dsp_cem      = 1'b1;
    assign bus.dsp_ceopmode = 1'b1;
    assign bus.dsp_cep      = r_t_p2;
    assign bus.dsp_rstp     = RST;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP48A1 slice closes the loop, expected
// dot products go into a scoreboard queue, and a negedge monitor checks results and slice controls.
module tb_dsp_mac_sequencer;
    localparam int LEN_W = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    dsp_mac_sequencer_if #(.LEN_W(LEN_W)) bus ();

    dsp_mac_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Slice model: A1/B1 -> M -> P with registered OPMODE
    logic signed [35:0] s_a1, s_b1, s_m;
    logic [7:0]         s_opr;
    logic signed [47:0] s_p;
    always @(posedge CLK) begin
        s_a1  <= {{18{bus.dsp_a[17]}}, bus.dsp_a};
        s_b1  <= {{18{bus.dsp_b[17]}}, bus.dsp_b};
        s_m   <= s_a1 * s_b1;
        s_opr <= bus.dsp_opmode;
        if (bus.dsp_rstp)
            s_p <= '0;
        else if (bus.dsp_cep)
            s_p <= ((s_opr[3:2] == 2'b10) ? s_p : 48'sd0)
                 + ((s_opr[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'sd0);
    end
    assign bus.dsp_p = s_p;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;
    int cmd_cyc = 0;
    int pairs_done = 0;
    int cep_cnt = 0;
    int results_seen = 0;
    logic [47:0] exp_q[$];
    logic acc_h0 = 1'b0, acc_h1 = 1'b0, first_h0 = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pops plus per-cycle slice-control checks
    always @(negedge CLK) begin
        logic       acc_now;
        logic       first_now;
        logic [47:0] e;
        if (RST) begin
            acc_h0   = 1'b0;
            acc_h1   = 1'b0;
            first_h0 = 1'b0;
        end else begin
            chk("dsp_cep_vs_accept", 48'(bus.dsp_cep), 48'(acc_h1));
            chk("dsp_opmode", 48'(bus.dsp_opmode), (acc_h0 && first_h0) ? 48'h01 : 48'h09);
            chk("dsp_ce_fixed", 48'({bus.dsp_cea, bus.dsp_ceb, bus.dsp_cem, bus.dsp_ceopmode}), 48'hF);
            chk("dsp_a_pass", 48'(bus.dsp_a), 48'(bus.in_a));
            chk("dsp_b_pass", 48'(bus.dsp_b), 48'(bus.in_b));
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %0h expected none", bus.res_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", bus.res_data, e);
                    results_seen++;
                end
            end
            acc_now   = bus.in_valid && bus.in_ready;
            first_now = acc_now && (pairs_done == 0);
            if (acc_now) pairs_done++;
            if (bus.dsp_cep) cep_cnt++;
            acc_h1   = acc_h0;
            acc_h0   = acc_now;
            first_h0 = first_now;
        end
    end

    task automatic send_cmd(input int n, input logic push, input logic [47:0] e);
        logic ok;
        ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 16'(n);
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("cmd_accept", 48'(ok), 48'd1);
        if (ok) begin
            cmd_cyc    = cyc;
            pairs_done = 0;
            if (push) exp_q.push_back(e);
        end
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_pair(input logic signed [17:0] a, input logic signed [17:0] b, input int gap);
        logic ok;
        ok = 1'b0;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) begin @(posedge CLK); #1; end
        end
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (bus.in_ready) begin
                ok = 1'b1;
                last_acc = cyc;
                break;
            end
        end
        chk("pair_accept", 48'(ok), 48'd1);
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input int hold, input int exp_lat, input int ref_c, input logic [47:0] e);
        logic ok;
        ok = 1'b0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (bus.res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("res_valid_seen", 48'(ok), 48'd1);
        if (ok) begin
            chk("res_latency", 48'(cyc - ref_c), 48'(exp_lat));
            chk("busy_in_result", 48'(bus.busy), 48'd1);
            for (int i = 0; i < hold; i++) begin
                @(negedge CLK);
                chk("hold_res_valid", 48'(bus.res_valid), 48'd1);
                chk("hold_res_data", bus.res_data, e);
                chk("hold_cmd_ready", 48'(bus.cmd_ready), 48'd0);
                chk("hold_in_ready", 48'(bus.in_ready), 48'd0);
            end
            @(posedge CLK); #1;
            bus.res_ready = 1'b1;
            @(posedge CLK); #1;
            bus.res_ready = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", 48'(bus.cmd_ready), 48'd0);
        chk("rst_in_ready", 48'(bus.in_ready), 48'd0);
        chk("rst_res_valid", 48'(bus.res_valid), 48'd0);
        chk("rst_res_data", bus.res_data, 48'd0);
        chk("rst_busy", 48'(bus.busy), 48'd0);
        chk("rst_dsp_cep", 48'(bus.dsp_cep), 48'd0);
        chk("rst_dsp_opmode", 48'(bus.dsp_opmode), 48'h09);
        chk("rst_dsp_rstp", 48'(bus.dsp_rstp), 48'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        chk_reset_outputs();
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("idle_cmd_ready", 48'(bus.cmd_ready), 48'd1);
        chk("idle_busy", 48'(bus.busy), 48'd0);

        // N=3 back-to-back: 2*3+4*5+6*7 = 68
        cep_cnt = 0;
        send_cmd(3, 1'b1, 48'd68);
        send_pair(18'sd2, 18'sd3, 0);
        send_pair(18'sd4, 18'sd5, 0);
        send_pair(18'sd6, 18'sd7, 0);
        wait_result(0, 4, last_acc, 48'd68);
        chk("cep_count_n3", 48'(cep_cnt), 48'd3);

        // Same stream with two-cycle bubbles
        cep_cnt = 0;
        send_cmd(3, 1'b1, 48'd68);
        send_pair(18'sd2, 18'sd3, 0);
        send_pair(18'sd4, 18'sd5, 2);
        send_pair(18'sd6, 18'sd7, 2);
        wait_result(0, 4, last_acc, 48'd68);
        chk("cep_count_gaps", 48'(cep_cnt), 48'd3);

        // N=0: immediate zero result, no slice activity
        cep_cnt = 0;
        send_cmd(0, 1'b1, 48'd0);
        wait_result(0, 1, cmd_cyc, 48'd0);
        chk("cep_count_n0", 48'(cep_cnt), 48'd0);

        // Two commands: the second starts from Z=0
        send_cmd(1, 1'b1, 48'd20000);
        send_pair(18'sd100, 18'sd200, 0);
        wait_result(0, 4, last_acc, 48'd20000);
        send_cmd(2, 1'b1, 48'd2);
        send_pair(18'sd1, 18'sd1, 0);
        send_pair(18'sd1, 18'sd1, 0);
        wait_result(0, 4, last_acc, 48'd2);

        // Negative product, result held 5 cycles under back-pressure
        send_cmd(1, 1'b1, 48'hFFFF_FFFF_FFF1);
        send_pair(-18'sd3, 18'sd5, 0);
        wait_result(5, 4, last_acc, 48'hFFFF_FFFF_FFF1);

        // Abort after 2 of 4 pairs; no result may appear
        send_cmd(4, 1'b0, 48'd0);
        send_pair(18'sd10, 18'sd10, 0);
        send_pair(18'sd11, 18'sd11, 0);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk_reset_outputs();
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        chk("abort_no_result", 48'(bus.res_valid), 48'd0);
        send_cmd(1, 1'b1, 48'd9);
        send_pair(18'sd3, 18'sd3, 0);
        wait_result(0, 4, last_acc, 48'd9);

        repeat (3) @(posedge CLK);
        #1;
        chk("results_seen", 48'(results_seen), 48'd7);
        chk("scoreboard_empty", 48'(exp_q.size()), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that sequences one DSP_48A1 slice as a multiply-accumulate engine.
- Accepts a dot-product command giving a length N.
- Streams N operand pairs (A,B) into the slice over a valid/ready interface and drives OPMODE and the clock enables with the slice's pipeline latency taken into account.
- Captures the accumulated P and returns it on a valid/ready result port.
- Target slice configuration: A0REG=0, B0REG=0, A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMODE5", RSTTYPE="SYNC".

Parameters:
- LEN_W, 16, width of command length and internal sample counter.
- PIPE_LAT, 3, cycles from operand on dsp_a/dsp_b to the P update being visible on dsp_p. Fixed by the slice configuration above; not overridable in practice.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted
- cmd_len  in  LEN_W  number of operand pairs N
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted
- in_a  in  18  operand A
- in_b  in  18  operand B
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_data  out  48  accumulated result
- busy  out  1  high whenever state is not IDLE
- dsp_a  out  18  to slice A
- dsp_b  out  18  to slice B
- dsp_opmode  out  8  to slice OPMODE
- dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode  out  1  slice enables
- dsp_cep  out  1  slice P enable
- dsp_rstp  out  1  slice P reset
- dsp_p  in  48  slice P output

Behaviour:
- Interface rule: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values:
  - cmd_ready=0, in_ready=0, res_valid=0, res_data=0, busy=0.
  - dsp_cep=0, dsp_opmode=8'h09.
  - Pipeline tags cleared, counter=0, state=IDLE.
  - dsp_rstp=1 while RST is high.
  - RST mid-operation aborts the command; no result is produced.
- Fixed outputs: dsp_cea=dsp_ceb=dsp_cem=dsp_ceopmode=1 always.
- Operand path: dsp_a=in_a and dsp_b=in_b, combinational pass-through.
- Accept: acc = in_valid & in_ready.
- Tag pipeline: t0=acc, plus first flag f0. Registered stages t1/f1 and t2/f2 follow.
- OPMODE:
  - dsp_opmode is driven from stage 1: f1 ? 8'h01 (X=M, Z=0) : 8'h09 (X=M, Z=P).
  - The slice registers it, so it applies when the multiply result reaches the post-adder.
- P enable: dsp_cep=t2. Bubbles never update P, so stalls on in_valid are harmless.
- FSM:
  - IDLE: cmd_ready=1. On cmd_valid, latch N.
    - If N==0: res_data<=0, go RESULT. No DSP activity.
    - Else: counter<=0, go STREAM.
  - STREAM: in_ready=1. On acc, f0=(counter==0) and counter++. On the acc with counter==N-1, go DRAIN.
  - DRAIN: in_ready=0. When t2 is registered for the last sample, i.e. exactly PIPE_LAT cycles after the last accept:
    - res_data<=dsp_p.
    - go RESULT.
  - RESULT: res_valid=1 and res_data held stable. On res_ready, go IDLE.
    - cmd_ready=0 here; the next command is accepted at the earliest in the first IDLE cycle.
- Timing:
  - Minimum latency from the last operand accept to res_valid is 4 cycles: 3 pipeline cycles plus 1 capture cycle.
  - Sustained throughput is 1 pair per cycle.
- Arithmetic:
  - Result is the raw 48-bit P value: sum of the 36-bit products, with the X mux sign-extending M.
  - Wrap-around is modulo 2^48. No saturation.
  - No carry-in: OPMODE[5]=0.
- Counter: N up to 2^LEN_W-1. The counter never wraps within a command.
- Simultaneous cmd_valid while busy: ignored (cmd_ready=0).

Test Plan:
- N=3, pairs (2,3),(4,5),(6,7) back-to-back -> res_valid 4 cycles after the third accept, res_data=68. dsp_cep high for exactly 3 cycles.
- Same stream with in_valid low for 2 cycles between pairs -> res_data=68. dsp_cep shows gaps matching the bubbles. OPMODE sequence 01,09,09 on accepted tags.
- N=0 -> res_valid the cycle after cmd accept, res_data=0, dsp_cep never high.
- Two commands: N=1 (100,200) then N=2 (1,1),(1,1) -> results 20000 then 2. The second result does not include the first (Z=0 on the first sample).
- res_ready held low 5 cycles -> res_valid and res_data stable. cmd_ready=0 and in_ready=0 throughout.
- RST asserted after 2 of 4 pairs -> outputs reach reset values next cycle, dsp_rstp=1, no res_valid. A following N=1 (3,3) command returns 9.
